// File: rtl/simon_seq.sv
// Simon-style memory game sequencer: appends a random 2-bit code per round,
// replays the stored sequence with timed on/off phases, then checks player presses.
// Outputs are decoded from registered state; reset clears state asynchronously.
module simon_seq #(
    parameter int MAX_LEN     = 16,
    parameter int STEP_CYCLES = 25_000_000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [1:0]                       rnd,
    input  logic                             btn_valid,
    input  logic [1:0]                       btn_code,
    output logic                             show_valid,
    output logic [1:0]                       show_code,
    output logic                             wait_input,
    output logic [$clog2(MAX_LEN+1)-1:0]     level,
    output logic                             win,
    output logic                             fail
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int IW = $clog2(MAX_LEN);
    localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    localparam logic [PW-1:0] PH_LAST = PW'(STEP_CYCLES - 1);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_APPEND   = 3'd1;
    localparam logic [2:0] S_SHOW_ON  = 3'd2;
    localparam logic [2:0] S_SHOW_OFF = 3'd3;
    localparam logic [2:0] S_INPUT    = 3'd4;
    localparam logic [2:0] S_WIN      = 3'd5;
    localparam logic [2:0] S_FAIL     = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [PW-1:0] ph_q, ph_d;
    logic [1:0]    mem_q [MAX_LEN];
    logic [1:0]    mem_d [MAX_LEN];

    logic          ph_last;
    logic          idx_last;

    // Phase and position qualifiers shared by the show and input states
    always_comb begin
        ph_last  = (ph_q == PH_LAST);
        idx_last = (LW'(idx_q) == (len_q - 1'b1));
    end

    // Next-state logic for the game sequencer and sequence storage
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        ph_d    = ph_q;
        mem_d   = mem_q;

        case (state_q)
            S_IDLE, S_WIN, S_FAIL: begin
                if (start) begin
                    len_d   = '0;
                    idx_d   = '0;
                    ph_d    = '0;
                    state_d = S_APPEND;
                end
            end

            S_APPEND: begin
                // Only slot len is written so earlier rounds stay intact
                for (int i = 0; i < MAX_LEN; i++) begin
                    if (LW'(i) == len_q) begin
                        mem_d[i] = rnd;
                    end
                end
                len_d   = len_q + 1'b1;
                idx_d   = '0;
                ph_d    = '0;
                state_d = S_SHOW_ON;
            end

            S_SHOW_ON: begin
                if (ph_last) begin
                    ph_d    = '0;
                    state_d = S_SHOW_OFF;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end

            S_SHOW_OFF: begin
                if (ph_last) begin
                    ph_d = '0;
                    if (idx_last) begin
                        idx_d   = '0;
                        state_d = S_INPUT;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_SHOW_ON;
                    end
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end

            S_INPUT: begin
                if (btn_valid) begin
                    if (btn_code == mem_q[idx_q]) begin
                        if (!idx_last) begin
                            idx_d = idx_q + 1'b1;
                        end else if (len_q < LEN_MAX) begin
                            state_d = S_APPEND;
                        end else begin
                            state_d = S_WIN;
                        end
                    end else begin
                        state_d = S_FAIL;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous reset back to an empty idle game
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            ph_q    <= '0;
            for (int i = 0; i < MAX_LEN; i++) begin
                mem_q[i] <= 2'b00;
            end
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            ph_q    <= ph_d;
            for (int i = 0; i < MAX_LEN; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Output decode; show_code is forced to zero outside the on phase
    always_comb begin
        show_valid = (state_q == S_SHOW_ON);
        show_code  = show_valid ? mem_q[idx_q] : 2'b00;
        wait_input = (state_q == S_INPUT);
        level      = len_q;
        win        = (state_q == S_WIN);
        fail       = (state_q == S_FAIL);
    end

endmodule

// File: tb/tb_simon_seq.sv
// Directed bench for simon_seq with STEP_CYCLES=2, MAX_LEN=4.
module tb_simon_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] rnd;
    logic       btn_valid;
    logic [1:0] btn_code;
    logic       show_valid;
    logic [1:0] show_code;
    logic       wait_input;
    logic [2:0] level;
    logic       win;
    logic       fail;

    int errors = 0;
    int checks = 0;

    // Reference copy of the sequence the bench has fed in through rnd
    logic [1:0] seq_m [4];

    simon_seq #(.MAX_LEN(4), .STEP_CYCLES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rnd        (rnd),
        .btn_valid  (btn_valid),
        .btn_code   (btn_code),
        .show_valid (show_valid),
        .show_code  (show_code),
        .wait_input (wait_input),
        .level      (level),
        .win        (win),
        .fail       (fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] o(input logic sv, input logic [1:0] sc, input logic wi,
                                     input int lv, input logic w, input logic f);
        return {sv, sc, wi, 3'(lv), w, f};
    endfunction

    task automatic chk(input string tag, input logic [8:0] exp);
        logic [8:0] obs;
        obs = {show_valid, show_code, wait_input, level, win, fail};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed={sv,code,wi,lvl,win,fail}=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called while the DUT sits in APPEND at length n-1: appends code and
    // checks the full replay of n steps, injecting ignored button presses.
    task automatic next_round(input int n, input logic [1:0] code);
        rnd = code;
        seq_m[n-1] = code;
        for (int k = 0; k < n; k++) begin
            btn_valid = 1'b1;
            btn_code  = ~seq_m[k];
            tick(); chk($sformatf("r%0d_on%0d_a", n, k), o(1, seq_m[k], 0, n, 0, 0));
            tick(); chk($sformatf("r%0d_on%0d_b", n, k), o(1, seq_m[k], 0, n, 0, 0));
            tick(); chk($sformatf("r%0d_off%0d_a", n, k), o(0, 2'd0, 0, n, 0, 0));
            if (k == n - 1) btn_valid = 1'b0;
            tick(); chk($sformatf("r%0d_off%0d_b", n, k), o(0, 2'd0, 0, n, 0, 0));
        end
        btn_valid = 1'b0;
        rnd = ~code;
        tick(); chk($sformatf("r%0d_input", n), o(0, 2'd0, 1, n, 0, 0));
    endtask

    // Enters the whole correct sequence of length n
    task automatic press_all(input int n);
        for (int k = 0; k < n; k++) begin
            btn_valid = 1'b1;
            btn_code  = seq_m[k];
            tick();
            btn_valid = 1'b0;
            if (k < n - 1)
                chk($sformatf("r%0d_press%0d", n, k), o(0, 2'd0, 1, n, 0, 0));
            else if (n < 4)
                chk($sformatf("r%0d_to_append", n), o(0, 2'd0, 0, n, 0, 0));
            else
                chk("to_win", o(0, 2'd0, 0, 4, 1, 0));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rnd = 2'd0; btn_valid = 1'b0; btn_code = 2'd0;
        #2;
        chk("reset_async", o(0, 2'd0, 0, 0, 0, 0));
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        chk("idle_after_reset", o(0, 2'd0, 0, 0, 0, 0));

        // Game 1: rounds with sequence {2,1,3}, then a wrong press
        start = 1'b1; rnd = 2'd2;
        tick(); start = 1'b0;
        chk("g1_append", o(0, 2'd0, 0, 0, 0, 0));
        next_round(1, 2'd2);
        press_all(1);
        next_round(2, 2'd1);
        start = 1'b1;
        tick(); start = 1'b0;
        chk("start_in_input", o(0, 2'd0, 1, 2, 0, 0));
        press_all(2);
        next_round(3, 2'd3);
        btn_valid = 1'b1; btn_code = 2'd2;
        tick();
        chk("r3_first_ok", o(0, 2'd0, 1, 3, 0, 0));
        btn_code = 2'd3;
        tick(); btn_valid = 1'b0;
        chk("wrong_to_fail", o(0, 2'd0, 0, 3, 0, 1));
        btn_valid = 1'b1; btn_code = 2'd1; rnd = 2'd0;
        tick(); tick(); btn_valid = 1'b0;
        chk("fail_hold", o(0, 2'd0, 0, 3, 0, 1));

        // Game 2: play to the full length of 4 and win
        start = 1'b1;
        tick(); start = 1'b0;
        chk("g2_append", o(0, 2'd0, 0, 0, 0, 0));
        next_round(1, 2'd3);
        press_all(1);
        next_round(2, 2'd0);
        press_all(2);
        next_round(3, 2'd1);
        press_all(3);
        next_round(4, 2'd2);
        press_all(4);
        btn_valid = 1'b1; btn_code = 2'd0;
        tick(); tick(); btn_valid = 1'b0;
        chk("win_hold", o(0, 2'd0, 0, 4, 1, 0));

        // Restart from WIN, then abort with an asynchronous reset mid-show
        start = 1'b1; rnd = 2'd1;
        tick(); start = 1'b0;
        chk("g3_append", o(0, 2'd0, 0, 0, 0, 0));
        tick();
        chk("g3_show_on", o(1, 2'd1, 0, 1, 0, 0));
        #2 rst = 1'b1;
        #1 chk("rst_mid_show", o(0, 2'd0, 0, 0, 0, 0));
        tick();
        rst = 1'b0;
        tick(); tick();
        chk("idle_after_abort", o(0, 2'd0, 0, 0, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/simon_seq.md
SIMON_SEQ -- requirements
Module: simon_seq

Interface
REQ-001 Parameter MAX_LEN, default 16, SHALL set the maximum sequence length in steps (2..32).
REQ-002 Parameter STEP_CYCLES, default 25_000_000, SHALL set the number of clk cycles in each show-on and each show-off phase (>=1).
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 start  input  1  SHALL be a one-cycle request to begin a new game.
REQ-006 rnd  input  2  SHALL be the random code from the LFSR, sampled only in APPEND.
REQ-007 btn_valid  input  1  SHALL be a one-cycle player press strobe.
REQ-008 btn_code  input  2  SHALL be the pressed code, valid when btn_valid=1.
REQ-009 show_valid  output  1  SHALL be high while a stored code is displayed.
REQ-010 show_code  output  2  SHALL be the displayed code; it SHALL be 0 when show_valid=0.
REQ-011 wait_input  output  1  SHALL be high only in INPUT.
REQ-012 level  output  $clog2(MAX_LEN+1)  SHALL be the current sequence length.
REQ-013 win  output  1  SHALL be high only in WIN.
REQ-014 fail  output  1  SHALL be high only in FAIL.

Function
REQ-015 States SHALL be IDLE, APPEND, SHOW_ON, SHOW_OFF, INPUT, WIN and FAIL; storage SHALL be MAX_LEN x 2-bit registers mem, plus idx, len and a phase counter.
REQ-016 In IDLE, WIN or FAIL, start=1 SHALL set len=0 and go to APPEND in the next cycle; start SHALL be ignored in every other state.
REQ-017 APPEND SHALL last one cycle: mem[len]<=rnd, len<=len+1, idx<=0, phase counter<=0, then go to SHOW_ON.
REQ-018 SHOW_ON SHALL drive show_valid=1 and show_code=mem[idx] for exactly STEP_CYCLES cycles, then go to SHOW_OFF.
REQ-019 SHOW_OFF SHALL drive show_valid=0 for exactly STEP_CYCLES cycles, then:
- if idx==len-1: go to INPUT with idx=0;
- else: idx+1, go to SHOW_ON.
REQ-020 In INPUT, btn_valid with btn_code==mem[idx] SHALL be handled as follows:
- if idx<len-1: idx+1, stay in INPUT;
- if idx==len-1 and len<MAX_LEN: go to APPEND;
- if idx==len-1 and len==MAX_LEN: go to WIN.
REQ-021 In INPUT, btn_valid with btn_code!=mem[idx] SHALL go to FAIL.
REQ-022 btn_valid outside INPUT SHALL be ignored with no state change.
REQ-023 level SHALL equal len; after APPEND it SHALL count 1..MAX_LEN and never wrap.
REQ-024 From APPEND, the first show_valid=1 SHALL appear one cycle later.
REQ-025 After the last SHOW_OFF cycle, wait_input SHALL rise in the next cycle.
REQ-026 WIN and FAIL SHALL hold, with len and mem unchanged, until start or rst.
REQ-027 Stored mem contents SHALL persist across rounds of one game; APPEND SHALL only write index len.

Reset
REQ-028 rst=1 SHALL force, immediately and regardless of clk:
- state=IDLE;
- len, idx and phase counter = 0;
- all outputs = 0.
REQ-029 Asserting rst mid-show or mid-input SHALL abort the game; mem contents after reset are don't-care.
REQ-030 On rst deassertion, the block SHALL stay in IDLE until start.

Verification (STEP_CYCLES=2, MAX_LEN=4)
REQ-031 Scenario 1: rst pulse during SHOW_ON -> all outputs 0 asynchronously; state IDLE; level=0.
REQ-032 Scenario 2: start with rnd=2 -> APPEND, then show_valid=1 with show_code=2 for 2 cycles, then show_valid=0 for 2 cycles, then wait_input=1 and level=1.
REQ-033 Scenario 3: round 2, sequence {2,1} -> shows 2 then 1, each 2 on / 2 off; press 2 then 1 -> APPEND, level=2->3.
REQ-034 Scenario 4: wrong code in INPUT (expected 1, pressed 3) -> fail=1 next cycle; level held; btn_valid and non-start inputs ignored; start -> level=1.
REQ-035 Scenario 5: correct full sequence at len=4 -> win=1 and level=4; later start -> level=1 and win=0.
REQ-036 Scenario 6: btn_valid during SHOW_ON/SHOW_OFF and start during INPUT -> no state, idx or level change.
